rob_retire_ctrl: RTL and testbench
==================================

// Module: rob_retire_ctrl
// PURPOSE
//  Retire-stage sequencer for the ROB. Each cycle it scans the N oldest ROB entries
//  (head order) and computes num_retiring, which the ROB consumes in the same cycle.
//  Also gates store commit to the store queue, sequences mispredict flush and halt,
//  and keeps the retired-instruction count.
// PARAMETERS
//  N        3   superscalar width; number of head slots scanned per cycle
//  NB       2   width of count ports; equals $clog2(N+1)
//  CNT_W    64  width of retired_count
// PORTS
//  clock            in   1      rising-edge clock
//  reset            in   1      asynchronous, active-high reset
//  head_valid       in   NB     valid head slots (count, 0..N; slots 0..head_valid-1)
//  head_complete    in   N      slot i has finished execution
//  head_is_store    in   N      slot i is a store
//  head_mispredict  in   N      slot i is a branch resolved mispredicted
//  head_halt        in   N      slot i is a halt/wfi
//  sq_commit_ready  in   1      store queue can accept one store commit this cycle
//  num_retiring     out  NB     entries the ROB frees this cycle (combinational)
//  sq_commit        out  1      one store retires this cycle (combinational)
//  flush            out  1      pipeline flush pulse (registered)
//  halted           out  1      core halted (registered, sticky)
//  retired_count    out  CNT_W  total retired instructions (registered)
// BEHAVIOUR
//  Reset (async): state=RUN, flush=0, halted=0, retired_count=0. While reset=1,
//   num_retiring=0 and sq_commit=0 regardless of inputs.
//  States: RUN, FLUSH, HALTED (2-bit encoding).
//  Combinational scan in RUN, slot i=0..N-1 in order; slot i retires iff:
//   i<head_valid; head_complete[i]; every slot <i retired; no slot <i had
//   mispredict or halt set; if head_is_store[i]: sq_commit_ready=1 and no store in
//   a slot <i retired this cycle (max one store per cycle).
//   First slot failing stops the scan; num_retiring = count of retired slots
//   (contiguous prefix). sq_commit=1 iff a retired slot is a store.
//   A mispredicting/halting slot itself retires; younger slots do not.
//  In FLUSH or HALTED: num_retiring=0, sq_commit=0.
//  Transitions (at clock edge):
//   RUN->HALTED if a retired slot has head_halt (halt wins over mispredict in
//    same slot); RUN->FLUSH if a retired slot has head_mispredict; else stay RUN.
//   FLUSH->RUN unconditionally after exactly one cycle.
//   HALTED->HALTED until reset.
//  flush = (state==FLUSH): one-cycle pulse in the cycle after the mispredicted
//   branch retires; ROB tail restore/entry discard is driven elsewhere off this pulse.
//  halted = (state==HALTED).
//  retired_count <= retired_count + num_retiring each cycle; wraps modulo 2^CNT_W.
//  head_valid>N is illegal; treated as N. Bits of head_* above head_valid ignored.
//  Reset asserted mid-flush or mid-halt: returns to RUN next cycle after deassert,
//   nothing retires while asserted.
// TESTING
//  1 N=3, head_valid=3, complete=3'b111, no store/branch -> num_retiring=3;
//    next cycle retired_count=3.
//  2 complete=3'b101, head_valid=3 -> num_retiring=1 (stop at slot 1 incomplete).
//  3 is_store=3'b011, complete=3'b111, sq_commit_ready=1 -> num_retiring=1,
//    sq_commit=1; same with sq_commit_ready=0 -> num_retiring=0, sq_commit=0.
//  4 mispredict=3'b010, complete=3'b111 -> num_retiring=2; next cycle flush=1,
//    num_retiring=0 even with complete heads; cycle after flush=0, retire resumes.
//  5 halt=3'b001, complete=3'b111 -> num_retiring=1; halted=1 from next cycle,
//    num_retiring stays 0 for 10+ cycles; assert reset -> halted=0, count=0.
//  6 head_valid=0 with complete=3'b111 -> num_retiring=0; reset asserted while
//    state=FLUSH -> flush drops immediately (async), state RUN after release.

Source files
------------

// File: rtl/rob_retire_ctrl.sv
// ROB retire sequencer: scans the N oldest entries and sizes the same-cycle retire count (combinational).
// Store commit waits on sq_commit_ready; flush and halt are registered states; no other backpressure.
module rob_retire_ctrl #(
  parameter int N     = 3,
  parameter int NB    = 2,
  parameter int CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NB-1:0]    head_valid,
  input  logic [N-1:0]     head_complete,
  input  logic [N-1:0]     head_is_store,
  input  logic [N-1:0]     head_mispredict,
  input  logic [N-1:0]     head_halt,
  input  logic             sq_commit_ready,
  output logic [NB-1:0]    num_retiring,
  output logic             sq_commit,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] retired_count
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [NB-1:0] valid_cnt;
  logic [NB-1:0] scan_cnt;
  logic          scan_store;
  logic          scan_halt;
  logic          scan_mispredict;
  logic          stop;
  logic          retire_en;

  // In-order head scan; the first slot that cannot retire ends the group.
  always_comb begin
    valid_cnt       = (head_valid > NB'(N)) ? NB'(N) : head_valid;
    scan_cnt        = '0;
    scan_store      = 1'b0;
    scan_halt       = 1'b0;
    scan_mispredict = 1'b0;
    stop            = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!stop) begin
        if ((NB'(i) >= valid_cnt) || !head_complete[i] ||
            (head_is_store[i] && (!sq_commit_ready || scan_store))) begin
          stop = 1'b1;
        end else begin
          scan_cnt = scan_cnt + NB'(1);
          if (head_is_store[i]) scan_store = 1'b1;
          // A redirecting slot retires itself but nothing younger.
          if (head_halt[i]) begin
            scan_halt = 1'b1;
            stop      = 1'b1;
          end else if (head_mispredict[i]) begin
            scan_mispredict = 1'b1;
            stop            = 1'b1;
          end
        end
      end
    end
  end

  assign retire_en    = (state == RUN) && !reset;
  assign num_retiring = retire_en ? scan_cnt : '0;
  assign sq_commit    = retire_en && scan_store;
  assign flush        = (state == FLUSH);
  assign halted       = (state == HALTED);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (scan_halt)            state_nxt = HALTED;
        else if (scan_mispredict) state_nxt = FLUSH;
      end
      FLUSH:   state_nxt = RUN;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      retired_count <= '0;
    end else begin
      state         <= state_nxt;
      retired_count <= retired_count + CNT_W'(num_retiring);
    end
  end

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Scoreboard bench for rob_retire_ctrl: directed scenarios then randomized traffic vs a reference model.
module tb_rob_retire_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  head_valid;
  logic [2:0]  head_complete, head_is_store, head_mispredict, head_halt;
  logic        sq_commit_ready;
  logic [1:0]  num_retiring;
  logic        sq_commit, flush, halted;
  logic [63:0] retired_count;

  rob_retire_ctrl #(.N(3), .NB(2), .CNT_W(64)) dut (
    .clock(clock), .reset(reset), .head_valid(head_valid),
    .head_complete(head_complete), .head_is_store(head_is_store),
    .head_mispredict(head_mispredict), .head_halt(head_halt),
    .sq_commit_ready(sq_commit_ready), .num_retiring(num_retiring),
    .sq_commit(sq_commit), .flush(flush), .halted(halted),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  nr;
    logic        sqc;
    logic        fl;
    logic        hl;
    logic [63:0] cnt;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  // Reference model state
  logic        m_flush  = 1'b0;
  logic        m_halted = 1'b0;
  logic [63:0] m_cnt    = '0;

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, expv);
  endtask

  // Retire group = shortest of: valid count, first incomplete, store limit, first redirect (inclusive).
  function automatic void model_scan(input logic [1:0] hv, input logic [2:0] c, st, mp, ht,
                                     input logic sqr, output int lim, output logic sqc,
                                     output logic hlt_o, output logic mp_o);
    int n;
    int stores[$];
    logic [3:0] mask;
    n   = (hv > 2'd3) ? 3 : int'(hv);
    lim = n;
    for (int k = n - 1; k >= 0; k--) if (!c[k]) lim = k;
    for (int k = 0; k < n; k++) if (st[k]) stores.push_back(k);
    if (!sqr && stores.size() > 0 && stores[0] < lim) lim = stores[0];
    if (sqr && stores.size() > 1 && stores[1] < lim) lim = stores[1];
    for (int k = lim - 1; k >= 0; k--) if (mp[k] || ht[k]) lim = k + 1;
    mask  = (4'd1 << lim) - 4'd1;
    sqc   = |({1'b0, st} & mask);
    hlt_o = (lim > 0) && ht[lim-1];
    mp_o  = (lim > 0) && mp[lim-1] && !ht[lim-1];
  endfunction

  task automatic cycle(input logic r, input logic [1:0] hv, input logic [2:0] c, st, mp, ht,
                       input logic sqr);
    exp_t e;
    int   lim;
    logic sqc, h, m;
    reset = r; head_valid = hv; head_complete = c; head_is_store = st;
    head_mispredict = mp; head_halt = ht; sq_commit_ready = sqr;
    model_scan(hv, c, st, mp, ht, sqr, lim, sqc, h, m);
    e.cyc = cyc;
    if (r) begin
      m_flush = 1'b0; m_halted = 1'b0; m_cnt = '0;
      e.nr = 2'd0; e.sqc = 1'b0; e.fl = 1'b0; e.hl = 1'b0; e.cnt = '0;
      exp_q.push_back(e);
    end else begin
      e.fl = m_flush; e.hl = m_halted; e.cnt = m_cnt;
      if (m_flush || m_halted) begin
        e.nr = 2'd0; e.sqc = 1'b0;
      end else begin
        e.nr = 2'(lim); e.sqc = sqc;
      end
      exp_q.push_back(e);
      m_cnt = m_cnt + 64'(e.nr);
      if (m_flush) m_flush = 1'b0;
      else if (!m_halted && h) m_halted = 1'b1;
      else if (!m_halted && m) m_flush = 1'b1;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("num_retiring",  e.cyc, 64'(num_retiring), 64'(e.nr));
      chk("sq_commit",     e.cyc, 64'(sq_commit),    64'(e.sqc));
      chk("flush",         e.cyc, 64'(flush),        64'(e.fl));
      chk("halted",        e.cyc, 64'(halted),       64'(e.hl));
      chk("retired_count", e.cyc, retired_count,     e.cnt);
    end
  end

  initial begin
    reset = 1'b1; head_valid = '0; head_complete = '0; head_is_store = '0;
    head_mispredict = '0; head_halt = '0; sq_commit_ready = 1'b0;
    @(posedge clock); #1;
    cycle(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    // full-width retire, then count visible
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(0, 0, 3'b000, 3'b000, 3'b000, 3'b000, 1);
    // incomplete slot 1 stops the group
    cycle(0, 3, 3'b101, 3'b000, 3'b000, 3'b000, 1);
    // one store per cycle; no commit without store queue room
    cycle(0, 3, 3'b111, 3'b011, 3'b000, 3'b000, 1);
    cycle(0, 3, 3'b111, 3'b011, 3'b000, 3'b000, 0);
    // mispredict in slot 1: flush cycle, then resume
    cycle(0, 3, 3'b111, 3'b000, 3'b010, 3'b000, 1);
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    // halt in slot 0 is sticky until reset
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b001, 1);
    repeat (11) cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(1, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    // no valid heads, then reset landing on the flush cycle
    cycle(0, 0, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(0, 3, 3'b111, 3'b000, 3'b100, 3'b000, 1);
    cycle(1, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    // halt and mispredict on the same slot: halt wins
    cycle(0, 3, 3'b111, 3'b000, 3'b001, 3'b001, 1);
    cycle(0, 3, 3'b111, 3'b000, 3'b000, 3'b000, 1);
    cycle(1, 0, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    for (int i = 0; i < 800; i++) begin
      logic [2:0] mp, ht;
      mp = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      ht = ($urandom_range(0, 11) == 0) ? 3'($urandom) : 3'b000;
      cycle(($urandom_range(0, 39) == 0), 2'($urandom), 3'($urandom | $urandom),
            3'($urandom & $urandom), mp, ht, 1'($urandom));
    end
    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(posedge clock);
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
